// File: rtl/mimo_qam_demap_pkg.sv
// Shared constants for the MIMO QAM demapper: default sizes, modulation codes,
// subcarrier-tracking state encoding and the bit-group layout of out_data.
package mimo_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int NFFT_DEF   = 64;

    localparam logic MOD_QPSK  = 1'b0;
    localparam logic MOD_16QAM = 1'b1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    // Each component owns two bits of out_data, X1_re in the top pair.
    localparam int OFF_X1_RE = 6;
    localparam int OFF_X1_IM = 4;
    localparam int OFF_X2_RE = 2;
    localparam int OFF_X2_IM = 0;

endpackage

// File: rtl/mimo_qam_demap_if.sv
// Ready/valid output stream from the demapper toward the de-interleaver.
interface mimo_qam_demap_if #(
    parameter int SC_W = 6
) ();

    logic            out_valid;
    logic            out_ready;
    logic [7:0]      out_data;
    logic [SC_W-1:0] out_sc_idx;
    logic            out_last;

    modport master (
        output out_valid,
        output out_data,
        output out_sc_idx,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_sc_idx,
        input  out_last,
        output out_ready
    );

endinterface

// File: rtl/mimo_qam_demap_slice.sv
// Combinational hard-decision slicer for one re or im component, Gray-coded
// as -3:00, -1:01, +1:11, +3:10; the lsb is forced to 0 in QPSK.
module qam_slice_2b
    import mimo_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int LVL    = 1024
) (
    input  logic signed [DATA_W-1:0] v,
    input  logic                     mode,
    output logic [1:0]               bits
);

    localparam logic [DATA_W:0] THR = (DATA_W+1)'(2 * LVL);
    localparam logic [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [DATA_W-1:0] MOST_POS = {1'b0, {(DATA_W-1){1'b1}}};

    logic [DATA_W-1:0] mag;

    // Saturating magnitude so the most negative input does not wrap to itself.
    always_comb begin
        mag = $unsigned(v);
        if (v[DATA_W-1]) begin
            if ($unsigned(v) == MOST_NEG) begin
                mag = MOST_POS;
            end else begin
                mag = $unsigned(-v);
            end
        end
    end

    assign bits[1] = ~v[DATA_W-1];
    assign bits[0] = (mode == MOD_16QAM) && ({1'b0, mag} < THR);

endmodule

// File: rtl/mimo_qam_demap.sv
// MIMO QAM hard demapper: slices both equalised streams, tags each entry with
// its subcarrier index and queues it in a FWFT FIFO that flags overflow.
module mimo_qam_demap
    import mimo_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int NFFT       = NFFT_DEF,
    parameter int LVL        = 1024,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    input  logic signed [DATA_W-1:0]      X1_re,
    input  logic signed [DATA_W-1:0]      X1_im,
    input  logic signed [DATA_W-1:0]      X2_re,
    input  logic signed [DATA_W-1:0]      X2_im,
    input  logic                          mod_sel,
    mimo_qam_demap_if.master              out_if,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt,
    output logic                          ovf_err,
    output logic [15:0]                   sym_cnt
);

    localparam int SC_W  = $clog2(NFFT);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int ENT_W = 8 + SC_W + 1;

    logic [0:0]      state;
    logic [SC_W-1:0] sc_cnt;
    logic            sym_mod;
    logic            cur_mod;
    logic            sc_last;
    logic [7:0]      slice_bits;

    // The first entry of a symbol uses mod_sel directly; later ones the latch.
    assign cur_mod = (state == ST_IDLE) ? mod_sel : sym_mod;
    assign sc_last = (sc_cnt == SC_W'(NFFT - 1));

    qam_slice_2b #(.DATA_W(DATA_W), .LVL(LVL)) u_x1_re (
        .v(X1_re), .mode(cur_mod), .bits(slice_bits[OFF_X1_RE+1:OFF_X1_RE]));
    qam_slice_2b #(.DATA_W(DATA_W), .LVL(LVL)) u_x1_im (
        .v(X1_im), .mode(cur_mod), .bits(slice_bits[OFF_X1_IM+1:OFF_X1_IM]));
    qam_slice_2b #(.DATA_W(DATA_W), .LVL(LVL)) u_x2_re (
        .v(X2_re), .mode(cur_mod), .bits(slice_bits[OFF_X2_RE+1:OFF_X2_RE]));
    qam_slice_2b #(.DATA_W(DATA_W), .LVL(LVL)) u_x2_im (
        .v(X2_im), .mode(cur_mod), .bits(slice_bits[OFF_X2_IM+1:OFF_X2_IM]));

    // Counters advance on every input, even dropped ones, so indices stay aligned.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            sc_cnt  <= '0;
            sym_mod <= MOD_QPSK;
            sym_cnt <= '0;
        end else if (in_valid) begin
            if (state == ST_IDLE) begin
                sym_mod <= mod_sel;
            end
            if (sc_last) begin
                state   <= ST_IDLE;
                sc_cnt  <= '0;
                sym_cnt <= sym_cnt + 16'd1;
            end else begin
                state   <= ST_RUN;
                sc_cnt  <= sc_cnt + SC_W'(1);
            end
        end
    end

    logic             s1_valid;
    logic [ENT_W-1:0] s1_ent;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_ent   <= '0;
        end else begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_ent <= {sc_last, sc_cnt, slice_bits};
            end
        end
    end

    logic [ENT_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             full;
    logic             rd_en;
    logic             wr_en;
    logic [ENT_W-1:0] rd_ent;

    assign full  = (fifo_cnt == (AW+1)'(FIFO_DEPTH));
    assign rd_en = out_if.out_valid && out_if.out_ready;
    assign wr_en = s1_valid && (!full || rd_en);

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr] <= s1_ent;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            ovf_err  <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (wr_en && !rd_en) begin
                fifo_cnt <= fifo_cnt + 1'b1;
            end else if (!wr_en && rd_en) begin
                fifo_cnt <= fifo_cnt - 1'b1;
            end
            if (s1_valid && full && !rd_en) begin
                ovf_err <= 1'b1;
            end
        end
    end

    // Stale memory words are masked so an empty FIFO presents all-zero fields.
    assign out_if.out_valid  = (fifo_cnt != '0);
    assign rd_ent            = out_if.out_valid ? mem[rd_ptr] : '0;
    assign out_if.out_data   = rd_ent[7:0];
    assign out_if.out_sc_idx = rd_ent[8 +: SC_W];
    assign out_if.out_last   = rd_ent[ENT_W-1];

endmodule
